cake_rand_gen: RTL and testbench
================================

Name: cake_rand_gen

Overview:
Generates the position for a new cake (food item) after the snake eats one. It sits directly upstream of the cake latch stage and drives that stage's rand_num/rand_drive pair. The pair follows a fixed two-beat protocol: the X coordinate on the rand_drive cycle, the Y coordinate on the following cycle. Coordinates come from a free-running 9-bit LFSR, are grid-aligned and range-checked, and fall back to a fixed safe position if the retry budget runs out.

Parameters:
SEED, 9'h1A5, LFSR reset value; must be non-zero
GRID_SHIFT, 4, low bits forced to zero (grid pitch 2^GRID_SHIFT pixels)
X_MIN, 16, inclusive lower bound for X
X_MAX, 496, inclusive upper bound for X
Y_MIN, 16, inclusive lower bound for Y
Y_MAX, 448, inclusive upper bound for Y
MAX_TRIES, 32, candidate draws allowed per axis before fallback
FALLBACK_X, 256, X used on exhaustion; must be grid-aligned and in range
FALLBACK_Y, 240, Y used on exhaustion; must be grid-aligned and in range

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
eat_req  in  1  one-cycle pulse from collision logic: cake eaten, new one needed
rand_num  out  9  coordinate bus to cake latch (X on drive beat, Y on next beat)
rand_drive  out  1  one-cycle strobe marking the X beat
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle pulse on the cycle after the Y beat

Behaviour:
- Reset is async on negedge rst_n. Reset values: lfsr=SEED, state=IDLE, rand_num=0, rand_drive=0, busy=0, done=0, pending=0, try_cnt=0, x_hold=0, y_hold=0.
- LFSR:
  - Advances every cycle, independent of state.
  - Update: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]} (x^9+x^5+1, period 511).
  - If lfsr is ever all-zero, the next value is SEED.
- Candidate (combinational): cand = {lfsr[8:GRID_SHIFT], GRID_SHIFT'b0}.
- FSM states: IDLE, SEEK_X, SEEK_Y, ISSUE_X, ISSUE_Y.
  - IDLE: eat_req or pending -> SEEK_X; clear pending; try_cnt=0.
  - SEEK_X: each cycle, if X_MIN<=cand<=X_MAX, then x_hold<=cand, try_cnt<=0, -> SEEK_Y. Otherwise try_cnt++. When try_cnt reaches MAX_TRIES-1 and the candidate still fails, x_hold<=FALLBACK_X and -> SEEK_Y.
  - SEEK_Y: identical to SEEK_X, using the Y bounds, y_hold and FALLBACK_Y; -> ISSUE_X.
  - ISSUE_X: registered outputs rand_num<=x_hold, rand_drive<=1; -> ISSUE_Y.
  - ISSUE_Y: rand_num<=y_hold, rand_drive<=0; -> IDLE with done<=1 on that transition.
- Output timing:
  - rand_drive is high for exactly one cycle per request.
  - rand_num carries X in the rand_drive cycle and Y in the next cycle, then holds Y until the next ISSUE_X.
  - This matches the downstream latch: X captured on the drive cycle, Y on the following cycle.
- Latency: eat_req to rand_drive is 3 cycles minimum (both candidates pass first try). The maximum is 2*MAX_TRIES+1.
- eat_req while busy: sets pending, at most one queued. Extra pulses while pending=1 are dropped. pending is serviced immediately after done.
- eat_req in the same cycle the FSM returns to IDLE: it is captured as pending, then served.
- busy = (state != IDLE), registered alongside state.
- Consecutive Y beat and next X beat can never be adjacent: at least SEEK_X and SEEK_Y sit between them.
- Reset mid-operation: any in-flight request is discarded; rand_drive drops asynchronously; no done is produced.
- Widths: comparisons are 9-bit unsigned; try_cnt is $clog2(MAX_TRIES) bits wide and never wraps, because the fallback fires first.

Decomposition:
- Shared package snake_pkg:
  - state enum for this FSM
  - GRID_SHIFT, the playfield bounds (X_MIN/X_MAX/Y_MIN/Y_MAX) and the fallback coordinates, since collision and display logic reuse them
- One natural sub-module, lfsr9: free-running LFSR with SEED parameter and zero-lock recovery, exporting the 9-bit state.
- The FSM, range check and output registers stay in cake_rand_gen.

Test Plan:
1. Reset: assert rst_n=0 mid-run -> rand_num=0, rand_drive=0, busy=0, done=0 immediately; the first lfsr value after release is 9'h1A5.
2. Nominal: eat_req pulse with both first candidates in range -> rand_drive high exactly 3 cycles later with rand_num=first cand; the next cycle carries the second cand; done the cycle after. Both values are multiples of 16 within the bounds, checked against a bench LFSR model.
3. Fallback: instantiate with X_MIN=X_MAX=9'h1F8 (unreachable because grid-aligned) and MAX_TRIES=4 -> rand_drive after 4+ cycles of SEEK_X, rand_num=256 on the X beat, then a legal Y.
4. Queueing: three eat_req pulses during one busy window -> exactly two rand_drive strobes in total; the second sequence starts directly after the first done.
5. Boundary: force bounds X_MIN=X_MAX=Y_MIN=Y_MAX=16 -> only cand==16 is accepted; outputs 16/16 or the fallback, never any other value.
6. Downstream pairing: connect to cake_create and run 100 random eat_req pulses -> rand_x/rand_y always equal the X/Y values issued, all grid-aligned and in range.

Source files
------------

// File: rtl/snake_pkg.sv
// Playfield geometry shared by the snake datapath, plus the cake generator state type.
package snake_pkg;

    localparam int unsigned COORD_W    = 9;
    localparam int unsigned GRID_SHIFT = 4;

    localparam logic [COORD_W-1:0] X_MIN      = 9'd16;
    localparam logic [COORD_W-1:0] X_MAX      = 9'd496;
    localparam logic [COORD_W-1:0] Y_MIN      = 9'd16;
    localparam logic [COORD_W-1:0] Y_MAX      = 9'd448;
    localparam logic [COORD_W-1:0] FALLBACK_X = 9'd256;
    localparam logic [COORD_W-1:0] FALLBACK_Y = 9'd240;

    typedef enum logic [2:0] {
        IDLE,
        SEEK_X,
        SEEK_Y,
        ISSUE_X,
        ISSUE_Y
    } cake_state_e;

endpackage

// File: rtl/cake_rand_gen_lfsr9.sv
// Free-running 9-bit Fibonacci LFSR (x^9 + x^5 + 1) that reloads SEED if it ever locks at zero.
module lfsr9 #(
    parameter logic [8:0] SEED = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] state_o
);

    logic [8:0] lfsr_q;
    logic [8:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/cake_rand_gen.sv
// Picks a grid-aligned, in-bounds cake position and hands it to the cake latch
// as an X beat (with rand_drive) followed by a Y beat.
module cake_rand_gen #(
    parameter logic [8:0]  SEED       = 9'h1A5,
    parameter int unsigned GRID_SHIFT = snake_pkg::GRID_SHIFT,
    parameter logic [8:0]  X_MIN      = snake_pkg::X_MIN,
    parameter logic [8:0]  X_MAX      = snake_pkg::X_MAX,
    parameter logic [8:0]  Y_MIN      = snake_pkg::Y_MIN,
    parameter logic [8:0]  Y_MAX      = snake_pkg::Y_MAX,
    parameter int unsigned MAX_TRIES  = 32,
    parameter logic [8:0]  FALLBACK_X = snake_pkg::FALLBACK_X,
    parameter logic [8:0]  FALLBACK_Y = snake_pkg::FALLBACK_Y
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eat_req,
    output logic [8:0] rand_num,
    output logic       rand_drive,
    output logic       busy,
    output logic       done
);

    import snake_pkg::*;

    localparam int unsigned         CNT_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [CNT_W-1:0]    TRY_LAST  = CNT_W'(MAX_TRIES - 1);
    localparam logic [8:0]          GRID_MASK = ~((9'd1 << GRID_SHIFT) - 9'd1);

    cake_state_e      state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] try_q, try_d;
    logic [8:0]       x_hold_q, x_hold_d;
    logic [8:0]       y_hold_q, y_hold_d;
    logic [8:0]       rand_num_q, rand_num_d;
    logic             drive_q, drive_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [8:0] lfsr;
    logic [8:0] cand;
    logic       x_ok;
    logic       y_ok;

    lfsr9 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );

    assign cand = lfsr & GRID_MASK;
    assign x_ok = (cand >= X_MIN) && (cand <= X_MAX);
    assign y_ok = (cand >= Y_MIN) && (cand <= Y_MAX);

    // Output registers are loaded on entry to each ISSUE state, so the X beat
    // coincides with ISSUE_X and the Y beat with ISSUE_Y.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        try_d      = try_q;
        x_hold_d   = x_hold_q;
        y_hold_d   = y_hold_q;
        rand_num_d = rand_num_q;
        drive_d    = 1'b0;
        done_d     = 1'b0;

        if (state_q != IDLE && eat_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (eat_req || pending_q) begin
                    pending_d = 1'b0;
                    try_d     = '0;
                    state_d   = SEEK_X;
                end
            end
            SEEK_X: begin
                if (x_ok || try_q == TRY_LAST) begin
                    x_hold_d = x_ok ? cand : FALLBACK_X;
                    try_d    = '0;
                    state_d  = SEEK_Y;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            SEEK_Y: begin
                if (y_ok || try_q == TRY_LAST) begin
                    y_hold_d   = y_ok ? cand : FALLBACK_Y;
                    try_d      = '0;
                    state_d    = ISSUE_X;
                    rand_num_d = x_hold_q;
                    drive_d    = 1'b1;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            ISSUE_X: begin
                rand_num_d = y_hold_q;
                state_d    = ISSUE_Y;
            end
            ISSUE_Y: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            try_q      <= '0;
            x_hold_q   <= '0;
            y_hold_q   <= '0;
            rand_num_q <= '0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            try_q      <= try_d;
            x_hold_q   <= x_hold_d;
            y_hold_q   <= y_hold_d;
            rand_num_q <= rand_num_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rand_num   = rand_num_q;
    assign rand_drive = drive_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cake_rand_gen.sv
// Bench for cake_rand_gen: three parameterisations driven by the same eat_req,
// each checked every cycle against a schedule model of request service.
module tb_cake_rand_gen;

    localparam int N  = 8192;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic eat_req;

    logic [8:0] num_w  [NI];
    logic       drv_w  [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic [8:0] lfsr_w [NI];

    always #5 clk = ~clk;

    cake_rand_gen dut0 (
        .clk(clk), .rst_n(rst_n), .eat_req(eat_req),
        .rand_num(num_w[0]), .rand_drive(drv_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    cake_rand_gen #(
        .X_MIN(9'h1F8), .X_MAX(9'h1F8), .MAX_TRIES(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .eat_req(eat_req),
        .rand_num(num_w[1]), .rand_drive(drv_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    cake_rand_gen #(
        .X_MIN(9'd16), .X_MAX(9'd16), .Y_MIN(9'd16), .Y_MAX(9'd16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .eat_req(eat_req),
        .rand_num(num_w[2]), .rand_drive(drv_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    assign lfsr_w[0] = dut0.u_lfsr.state_o;
    assign lfsr_w[1] = dut1.u_lfsr.state_o;
    assign lfsr_w[2] = dut2.u_lfsr.state_o;

    // Per-instance bounds as seen by the model
    int xmin [NI] = '{16, 504, 16};
    int xmax [NI] = '{496, 504, 16};
    int ymin [NI] = '{16, 16, 16};
    int ymax [NI] = '{448, 448, 16};
    int maxt [NI] = '{32, 4, 32};
    localparam int FBX = 256;
    localparam int FBY = 240;

    int         seq    [N];
    bit         e_drv  [NI][N];
    bit         e_busy [NI][N];
    bit         e_done [NI][N];
    int         e_num  [NI][N];
    int         e_px   [NI][N];
    int         e_py   [NI][N];
    int         free_at[NI];
    bit         pend   [NI];

    int cyc = 0;
    int seg = 0;
    int q_lo = 0;
    int q_hi = 0;
    int q_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        seq[0] = 'h1A5;
        for (int k = 1; k < N; k++) begin
            int p;
            p = seq[k-1];
            if (p == 0) seq[k] = 'h1A5;
            else        seq[k] = ((p * 2) % 512) + (((p / 256) + (p / 16)) % 2);
        end
    end

    function automatic int grid(input int v);
        return (v / 16) * 16;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Serve a request whose SEEK phase begins the cycle after s.
    task automatic schedule(input int i, input int s);
        int a, b, x, y, d, v;
        a = maxt[i]; x = FBX;
        for (int k = 0; k < maxt[i]; k++) begin
            v = grid(seq[s + 1 + k]);
            if (v >= xmin[i] && v <= xmax[i]) begin x = v; a = k + 1; break; end
        end
        b = maxt[i]; y = FBY;
        for (int k = 0; k < maxt[i]; k++) begin
            v = grid(seq[s + a + 1 + k]);
            if (v >= ymin[i] && v <= ymax[i]) begin y = v; b = k + 1; break; end
        end
        d = s + a + b + 1;
        for (int k = s + 1; k <= d + 1 && k < N; k++) e_busy[i][k] = 1'b1;
        if (d + 2 < N) begin
            e_drv[i][d] = 1'b1;
            e_num[i][d] = x;
            for (int k = d + 1; k < N; k++) e_num[i][k] = y;
            e_done[i][d + 2] = 1'b1;
            e_px[i][d + 2] = x;
            e_py[i][d + 2] = y;
        end
        free_at[i] = d + 2;
    endtask

    task automatic model_step(input int i, input int c, input bit eat);
        if (c >= free_at[i]) begin
            if (eat || pend[i]) begin
                schedule(i, c);
                pend[i] = 1'b0;
            end
        end else if (eat) begin
            pend[i] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            for (int i = 0; i < NI; i++) begin
                free_at[i] = 0;
                pend[i] = 1'b0;
                for (int k = 0; k < N; k++) begin
                    e_drv[i][k] = 1'b0; e_busy[i][k] = 1'b0; e_done[i][k] = 1'b0;
                    e_num[i][k] = 0; e_px[i][k] = 0; e_py[i][k] = 0;
                end
            end
        end else begin
            for (int i = 0; i < NI; i++) model_step(i, cyc, eat_req);
            cyc = cyc + 1;
        end
    end

    bit rst_chk_done = 1'b0;
    bit prev_drv [NI] = '{1'b0, 1'b0, 1'b0};
    int latch_x = 0;
    int latch_y = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!rst_chk_done) begin
                #1;
                for (int i = 0; i < NI; i++) begin
                    chk("rst_rand_num", num_w[i], 0);
                    chk("rst_rand_drive", drv_w[i], 0);
                    chk("rst_busy", busy_w[i], 0);
                    chk("rst_done", done_w[i], 0);
                end
                rst_chk_done = 1'b1;
            end
            for (int i = 0; i < NI; i++) prev_drv[i] = 1'b0;
        end else if (cyc < N) begin
            rst_chk_done = 1'b0;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("drive[%0d]", i), drv_w[i], e_drv[i][cyc]);
                chk($sformatf("num[%0d]", i), num_w[i], e_num[i][cyc]);
                chk($sformatf("busy[%0d]", i), busy_w[i], e_busy[i][cyc]);
                chk($sformatf("done[%0d]", i), done_w[i], e_done[i][cyc]);
                chk($sformatf("lfsr[%0d]", i), lfsr_w[i], seq[cyc]);
                if (cyc == 0) chk($sformatf("lfsr_seed[%0d]", i), lfsr_w[i], 'h1A5);
            end
            // Hand-computed first request: lfsr 1A5,14B,097,12F,05F,0BF
            if (seg == 1) begin
                if (cyc == 3) begin chk("lit_x_drive", drv_w[0], 1); chk("lit_x", num_w[0], 320); end
                if (cyc == 4) begin chk("lit_y", num_w[0], 144); chk("lit_y_drive", drv_w[0], 0); end
                if (cyc == 5) begin chk("lit_done", done_w[0], 1); chk("lit_idle", busy_w[0], 0); end
                if (cyc == 5) chk("lit_fb_nodrive", drv_w[1], 0);
                if (cyc == 6) begin chk("lit_fb_drive", drv_w[1], 1); chk("lit_fb_x", num_w[1], 256); end
                if (cyc == 7) chk("lit_fb_y", num_w[1], 176);
                if (cyc == 8) chk("lit_fb_done", done_w[1], 1);
            end
            if (drv_w[0]) begin
                latch_x = num_w[0];
                chk("x_legal", (num_w[0] % 16 == 0 && num_w[0] >= 16 && num_w[0] <= 496), 1);
            end
            if (prev_drv[0]) begin
                latch_y = num_w[0];
                chk("y_legal", (num_w[0] % 16 == 0 && num_w[0] >= 16 && num_w[0] <= 448), 1);
            end
            if (e_done[0][cyc]) begin
                chk("latch_x", latch_x, e_px[0][cyc]);
                chk("latch_y", latch_y, e_py[0][cyc]);
            end
            if (drv_w[2])    chk("bnd16_x", (num_w[2] == 16 || num_w[2] == 256), 1);
            if (prev_drv[2]) chk("bnd16_y", (num_w[2] == 16 || num_w[2] == 240), 1);
            if (q_hi != 0 && cyc >= q_lo && cyc < q_hi && drv_w[0]) q_cnt++;
            if (q_hi != 0 && cyc == q_hi) chk("queue_strobes", q_cnt, 2);
            for (int i = 0; i < NI; i++) prev_drv[i] = drv_w[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        eat_req = 1'b0;
        tick(3);

        seg = 1;
        rst_n = 1'b1;
        eat_req = 1'b1;
        tick(1);
        eat_req = 1'b0;
        tick(3);
        eat_req = 1'b1;
        tick(1);
        eat_req = 1'b0;
        tick(200);

        seg = 2;
        q_cnt = 0;
        q_lo = cyc;
        q_hi = cyc + 150;
        for (int p = 0; p < 3; p++) begin
            eat_req = 1'b1;
            tick(1);
            eat_req = 1'b0;
            tick(1);
        end
        tick(160);
        q_hi = 0;

        for (int k = 0; k < 100; k++) begin
            if (k == 60) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            eat_req = 1'b1;
            tick(1);
            eat_req = 1'b0;
            tick($urandom_range(1, 25));
        end
        tick(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
